// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: shares one external combinational ALU between two
// requesters (port 0 = integer EX stage, port 1 = debug/CSR side-path).
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   reqN_valid/ready         request handshake, N = 0,1
//   reqN_op1/op2/ctrl        request operands and ALU op code
//   rspN_valid/ready         response handshake (one-entry result buffer)
//   rspN_data/err            result, err=1 when op code was illegal (data=0)
//   alu_op1/op2/ctrl         to the external ALU
//   alu_out                  from the external ALU
//   last_grant               round-robin pointer (most recently granted port)
//
// Op code encoding (SLL..LUI = 0..10); codes 11..15 are illegal.

// One-entry response buffer for a single port.
module alu_share_rsp_buf #(
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              grant_i,
  input  logic              ready_i,
  input  logic [DATA_W-1:0] result_i,
  input  logic              illegal_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o,
  output logic              err_o
);
  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              err_q, err_d;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    err_d   = err_q;
    if (grant_i) begin
      valid_d = 1'b1;
      // Illegal codes may leave the ALU output undefined; never forward it.
      data_d  = illegal_i ? '0 : result_i;
      err_d   = illegal_i;
    end else if (valid_q && ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign err_o   = err_q;
endmodule

module alu_share_arbiter #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_op1,
  input  logic [DATA_W-1:0] req0_op2,
  input  logic [CTRL_W-1:0] req0_ctrl,
  output logic              rsp0_valid,
  input  logic              rsp0_ready,
  output logic [DATA_W-1:0] rsp0_data,
  output logic              rsp0_err,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_op1,
  input  logic [DATA_W-1:0] req1_op2,
  input  logic [CTRL_W-1:0] req1_ctrl,
  output logic              rsp1_valid,
  input  logic              rsp1_ready,
  output logic [DATA_W-1:0] rsp1_data,
  output logic              rsp1_err,
  output logic [DATA_W-1:0] alu_op1,
  output logic [DATA_W-1:0] alu_op2,
  output logic [CTRL_W-1:0] alu_ctrl,
  input  logic [DATA_W-1:0] alu_out,
  output logic              last_grant
);
  localparam int NUM_PORTS = 2;

  localparam logic [CTRL_W-1:0] OP_SLL  = CTRL_W'(0);
  localparam logic [CTRL_W-1:0] OP_SRL  = CTRL_W'(1);
  localparam logic [CTRL_W-1:0] OP_SRA  = CTRL_W'(2);
  localparam logic [CTRL_W-1:0] OP_ADD  = CTRL_W'(3);
  localparam logic [CTRL_W-1:0] OP_SUB  = CTRL_W'(4);
  localparam logic [CTRL_W-1:0] OP_XOR  = CTRL_W'(5);
  localparam logic [CTRL_W-1:0] OP_OR   = CTRL_W'(6);
  localparam logic [CTRL_W-1:0] OP_AND  = CTRL_W'(7);
  localparam logic [CTRL_W-1:0] OP_SLT  = CTRL_W'(8);
  localparam logic [CTRL_W-1:0] OP_SLTU = CTRL_W'(9);
  localparam logic [CTRL_W-1:0] OP_LUI  = CTRL_W'(10);

  logic [NUM_PORTS-1:0]             req_vld, rsp_vld, rsp_rdy, buf_free, elig, gnt;
  logic [NUM_PORTS-1:0][DATA_W-1:0] rsp_dat;
  logic [NUM_PORTS-1:0]             rsp_err;
  logic                             last_grant_q, last_grant_d;
  logic                             illegal;

  assign req_vld = {req1_valid, req0_valid};
  assign rsp_rdy = {rsp1_ready, rsp0_ready};

  // A full buffer being drained this cycle can be refilled in the same cycle.
  assign buf_free = ~rsp_vld | rsp_rdy;
  assign elig     = req_vld & buf_free & {NUM_PORTS{~rst}};

  always_comb begin
    gnt = elig;
    if (&elig) gnt = last_grant_q ? 2'b01 : 2'b10;
  end

  assign req0_ready = gnt[0];
  assign req1_ready = gnt[1];

  // Port 0 fields when idle keep the ALU inputs defined.
  assign alu_op1  = gnt[1] ? req1_op1  : req0_op1;
  assign alu_op2  = gnt[1] ? req1_op2  : req0_op2;
  assign alu_ctrl = gnt[1] ? req1_ctrl : req0_ctrl;

  // Only the granted op reaches a buffer, so one decoder on the muxed code suffices.
  always_comb begin
    case (alu_ctrl)
      OP_SLL, OP_SRL, OP_SRA, OP_ADD, OP_SUB, OP_XOR,
      OP_OR, OP_AND, OP_SLT, OP_SLTU, OP_LUI: illegal = 1'b0;
      default:                                illegal = 1'b1;
    endcase
  end

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_buf
    alu_share_rsp_buf #(.DATA_W(DATA_W)) u_buf (
      .clk_i     (clk),
      .rst_i     (rst),
      .grant_i   (gnt[i]),
      .ready_i   (rsp_rdy[i]),
      .result_i  (alu_out),
      .illegal_i (illegal),
      .valid_o   (rsp_vld[i]),
      .data_o    (rsp_dat[i]),
      .err_o     (rsp_err[i])
    );
  end

  assign rsp0_valid = rsp_vld[0];
  assign rsp0_data  = rsp_dat[0];
  assign rsp0_err   = rsp_err[0];
  assign rsp1_valid = rsp_vld[1];
  assign rsp1_data  = rsp_dat[1];
  assign rsp1_err   = rsp_err[1];

  always_comb begin
    last_grant_d = last_grant_q;
    if (gnt[0])      last_grant_d = 1'b0;
    else if (gnt[1]) last_grant_d = 1'b1;
  end

  // Pointer resets to 1 so port 0 wins the first contended cycle.
  always_ff @(posedge clk) begin
    if (rst) last_grant_q <= 1'b1;
    else     last_grant_q <= last_grant_d;
  end

  assign last_grant = last_grant_q;
endmodule

// File: tb/tb_alu_share_arbiter.sv
module tb_alu_share_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req0_ready, rsp0_valid, rsp0_ready, rsp0_err;
  logic [31:0] req0_op1, req0_op2, rsp0_data;
  logic [3:0]  req0_ctrl;
  logic        req1_valid, req1_ready, rsp1_valid, rsp1_ready, rsp1_err;
  logic [31:0] req1_op1, req1_op2, rsp1_data;
  logic [3:0]  req1_ctrl;
  logic [31:0] alu_op1, alu_op2, alu_out;
  logic [3:0]  alu_ctrl;
  logic        last_grant;

  int vecs = 0;
  int miss = 0;
  bit chk_en = 0;

  always #5 clk = ~clk;

  alu_share_arbiter #(.DATA_W(32), .CTRL_W(4)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op1(req0_op1),
    .req0_op2(req0_op2), .req0_ctrl(req0_ctrl), .rsp0_valid(rsp0_valid),
    .rsp0_ready(rsp0_ready), .rsp0_data(rsp0_data), .rsp0_err(rsp0_err),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op1(req1_op1),
    .req1_op2(req1_op2), .req1_ctrl(req1_ctrl), .rsp1_valid(rsp1_valid),
    .rsp1_ready(rsp1_ready), .rsp1_data(rsp1_data), .rsp1_err(rsp1_err),
    .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_ctrl(alu_ctrl),
    .alu_out(alu_out), .last_grant(last_grant)
  );

  // Reference ALU; illegal codes produce garbage that must never reach a response.
  function automatic logic [31:0] ref_alu(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    case (c)
      4'd0:    return a << b[4:0];
      4'd1:    return a >> b[4:0];
      4'd2:    return $signed(a) >>> b[4:0];
      4'd3:    return a + b;
      4'd4:    return a - b;
      4'd5:    return a ^ b;
      4'd6:    return a | b;
      4'd7:    return a & b;
      4'd8:    return {31'd0, $signed(a) < $signed(b)};
      4'd9:    return {31'd0, a < b};
      4'd10:   return b;
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  assign alu_out = ref_alu(alu_ctrl, alu_op1, alu_op2);

  // Behavioural model: buffer contents per port plus the last-granted port.
  logic [1:0]  m_vld;
  logic [31:0] m_dat [2];
  logic        m_err [2];
  logic        m_lg;

  function automatic int model_grant();
    bit e0, e1;
    if (rst) return -1;
    e0 = req0_valid && (!m_vld[0] || rsp0_ready);
    e1 = req1_valid && (!m_vld[1] || rsp1_ready);
    if (e0 && e1) return (m_lg == 1'b0) ? 1 : 0;
    if (e0) return 0;
    if (e1) return 1;
    return -1;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      miss++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    int          g;
    logic [3:0]  c;
    logic [31:0] a, b;
    g = model_grant();
    if (rst) begin
      m_vld  <= 2'b00;
      m_dat[0] <= '0; m_dat[1] <= '0;
      m_err[0] <= 1'b0; m_err[1] <= 1'b0;
      m_lg   <= 1'b1;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (g == i) begin
          c = (i == 0) ? req0_ctrl : req1_ctrl;
          a = (i == 0) ? req0_op1  : req1_op1;
          b = (i == 0) ? req0_op2  : req1_op2;
          m_vld[i] <= 1'b1;
          m_dat[i] <= (c > 4'd10) ? 32'd0 : ref_alu(c, a, b);
          m_err[i] <= (c > 4'd10);
        end else if (m_vld[i] && ((i == 0) ? rsp0_ready : rsp1_ready)) begin
          m_vld[i] <= 1'b0;
        end
      end
      if (g >= 0) m_lg <= g[0];
    end
  end

  always @(negedge clk) begin
    int g;
    if (chk_en) begin
      g = model_grant();
      chk("req0_ready", {31'd0, req0_ready}, {31'd0, g == 0});
      chk("req1_ready", {31'd0, req1_ready}, {31'd0, g == 1});
      chk("rsp0_valid", {31'd0, rsp0_valid}, {31'd0, m_vld[0]});
      chk("rsp1_valid", {31'd0, rsp1_valid}, {31'd0, m_vld[1]});
      chk("rsp0_data", rsp0_data, m_dat[0]);
      chk("rsp1_data", rsp1_data, m_dat[1]);
      chk("rsp0_err", {31'd0, rsp0_err}, {31'd0, m_err[0]});
      chk("rsp1_err", {31'd0, rsp1_err}, {31'd0, m_err[1]});
      chk("last_grant", {31'd0, last_grant}, {31'd0, m_lg});
      if (g >= 0) begin
        chk("alu_op1", alu_op1, g == 1 ? req1_op1 : req0_op1);
        chk("alu_ctrl", {28'd0, alu_ctrl}, {28'd0, g == 1 ? req1_ctrl : req0_ctrl});
      end
      chk("no_x", {31'd0, $isunknown({req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp0_data,
          rsp1_data, rsp0_err, rsp1_err, alu_op1, alu_op2, alu_ctrl, last_grant})}, 32'd0);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set0(input logic v, input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    req0_valid = v; req0_ctrl = c; req0_op1 = a; req0_op2 = b;
  endtask

  task automatic set1(input logic v, input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    req1_valid = v; req1_ctrl = c; req1_op1 = a; req1_op2 = b;
  endtask

  initial begin
    rst = 1'b1;
    set0(0, 4'd0, 0, 0);
    set1(0, 4'd0, 0, 0);
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    step();
    chk_en = 1;
    step();
    chk("reset_lg", {31'd0, last_grant}, 32'd1);
    chk("reset_v0", {31'd0, rsp0_valid}, 32'd0);

    // Single ADD on port 0.
    rst = 1'b0;
    set0(1, 4'd3, 32'd5, 32'd3);
    @(negedge clk);
    chk("add_ready", {31'd0, req0_ready}, 32'd1);
    step();
    set0(0, 4'd3, 0, 0);
    @(negedge clk);
    chk("add_valid", {31'd0, rsp0_valid}, 32'd1);
    chk("add_data", rsp0_data, 32'd8);
    chk("add_lg", {31'd0, last_grant}, 32'd0);
    step();

    // Contention: grants alternate 0,1,0,1 from a fresh pointer.
    rst = 1'b1;
    step();
    rst = 1'b0;
    set0(1, 4'd4, 32'd10, 32'd4);
    set1(1, 4'd8, 32'hFFFF_FFFF, 32'd1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("alt_g0", {31'd0, req0_ready}, (k % 2 == 0) ? 32'd1 : 32'd0);
      chk("alt_g1", {31'd0, req1_ready}, (k % 2 == 1) ? 32'd1 : 32'd0);
      if (k >= 1) chk("sub_data", rsp0_data, 32'd6);
      if (k >= 2) chk("slt_data", rsp1_data, 32'd1);
      step();
    end
    set0(0, 4'd0, 0, 0);
    set1(0, 4'd0, 0, 0);
    step();

    // Backpressure on port 1.
    rsp1_ready = 1'b0;
    set1(1, 4'd2, 32'h8000_0000, 32'd4);
    step();
    set1(1, 4'd3, 32'd1, 32'd1);
    set0(1, 4'd3, 32'd2, 32'd2);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("sra_data", rsp1_data, 32'hF800_0000);
      chk("bp_g1", {31'd0, req1_ready}, 32'd0);
      chk("bp_g0", {31'd0, req0_ready}, 32'd1);
      step();
    end
    rsp1_ready = 1'b1;
    @(negedge clk);
    chk("refill_g1", {31'd0, req1_ready}, 32'd1);
    step();
    set0(0, 4'd0, 0, 0);
    set1(0, 4'd0, 0, 0);
    @(negedge clk);
    chk("refill_data", rsp1_data, 32'd2);
    chk("refill_v", {31'd0, rsp1_valid}, 32'd1);
    step();

    // Illegal op code.
    set0(1, 4'hF, 32'd7, 32'd9);
    @(negedge clk);
    chk("ill_ready", {31'd0, req0_ready}, 32'd1);
    step();
    set0(0, 4'd0, 0, 0);
    @(negedge clk);
    chk("ill_valid", {31'd0, rsp0_valid}, 32'd1);
    chk("ill_err", {31'd0, rsp0_err}, 32'd1);
    chk("ill_data", rsp0_data, 32'd0);
    step();

    // Reset with both buffers full and both requests pending.
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    set0(1, 4'd3, 32'd1, 32'd2);
    set1(1, 4'd5, 32'hF0F0, 32'h0FF0);
    step();
    step();
    @(negedge clk);
    chk("full_v0", {31'd0, rsp0_valid}, 32'd1);
    chk("full_v1", {31'd0, rsp1_valid}, 32'd1);
    rst = 1'b1;
    #1;
    chk("rst_rdy0", {31'd0, req0_ready}, 32'd0);
    chk("rst_rdy1", {31'd0, req1_ready}, 32'd0);
    step();
    rst = 1'b0;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    @(negedge clk);
    chk("post_v0", {31'd0, rsp0_valid}, 32'd0);
    chk("post_v1", {31'd0, rsp1_valid}, 32'd0);
    chk("post_lg", {31'd0, last_grant}, 32'd1);
    chk("post_g0", {31'd0, req0_ready}, 32'd1);
    chk("post_g1", {31'd0, req1_ready}, 32'd0);
    step();
    set0(0, 4'd0, 0, 0);
    set1(0, 4'd0, 0, 0);
    step();

    // LUI on port 1 alone.
    set1(1, 4'd10, 32'h0000_AAAA, 32'h1234_5000);
    @(negedge clk);
    chk("lui_g0", {31'd0, req0_ready}, 32'd0);
    chk("lui_g1", {31'd0, req1_ready}, 32'd1);
    step();
    set1(0, 4'd0, 0, 0);
    @(negedge clk);
    chk("lui_data", rsp1_data, 32'h1234_5000);
    chk("lui_valid", {31'd0, rsp1_valid}, 32'd1);
    chk("lui_g0b", {31'd0, req0_ready}, 32'd0);
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end
endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares one combinational ALU between two requesters: port 0 is the integer pipeline EX stage; port 1 is the debug/CSR side-path.
- Each requester has a valid/ready request channel and a valid/ready response channel with a one-entry result buffer.
- The ALU is instantiated outside this block and wired through the alu_* ports.
- Arbitration is round-robin. Operation codes are the `SLL/`SRL/`SRA/`ADD/`SUB/`XOR/`OR/`AND/`SLT/`SLTU/`LUI macros from Parameters.v.

Parameters:
- DATA_W, 32, operand/result width; must match the ALU.
- CTRL_W, 4, width of the ALU control code.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- req0_valid  input  1  port-0 request valid.
- req0_ready  output  1  port-0 request accepted this cycle when high with req0_valid.
- req0_op1  input  DATA_W  port-0 operand 1.
- req0_op2  input  DATA_W  port-0 operand 2.
- req0_ctrl  input  CTRL_W  port-0 ALU op code.
- rsp0_valid  output  1  port-0 result available.
- rsp0_ready  input  1  port-0 consumer takes the result.
- rsp0_data  output  DATA_W  port-0 result.
- rsp0_err  output  1  port-0 op code was illegal.
- req1_* / rsp1_*: identical set for port 1.
- alu_op1  output  DATA_W  to ALU Operand1.
- alu_op2  output  DATA_W  to ALU Operand2.
- alu_ctrl  output  CTRL_W  to ALU AluContrl.
- alu_out  input  DATA_W  from ALU AluOut.
- last_grant  output  1  port granted most recently (round-robin pointer).

Behaviour:
- Reset (clk edge with rst=1): rsp0_valid=rsp1_valid=0, rsp*_data=0, rsp*_err=0, last_grant=1 so port 0 has first priority. Reset mid-operation discards buffered results. Requests presented during reset are not accepted; req*_ready is 0 while rst=1.
- Eligibility: port i is eligible when reqi_valid=1 and its buffer is free. Free means rspi_valid=0, or rspi_valid=1 and rspi_ready=1 in the same cycle (drain-and-refill).
- Grant, combinational:
  - Only one port eligible: grant it.
  - Both eligible: grant the port != last_grant.
  - None eligible: no grant.
- reqi_ready = granted_i. At most one ready is high per cycle.
- ALU mux: alu_op1/op2/ctrl carry the granted port's fields. With no grant they carry port-0 fields; this is don't-care but must never be X.
- Capture: on the clk edge with grant to port i:
  - rspi_data <= alu_out, or 0 if illegal.
  - rspi_err <= illegal.
  - rspi_valid <= 1.
  - last_grant <= i.
- Latency: request accepted at edge N gives rsp valid after edge N, i.e. visible in cycle N+1. Sustained throughput is one op per cycle total.
- Legal codes are exactly the eleven macros listed. Any other CTRL value is illegal: the response is still generated with err=1 and data=0, and no X may propagate.
- Drain: rspi_valid && rspi_ready with no new grant to i gives rspi_valid <= 0. rspi_data and rspi_err hold their value until overwritten.
- Response stability: while rspi_valid=1 and rspi_ready=0, rspi_data and rspi_err must not change, and the port's buffer is not free.
- Starvation bound: a continuously eligible port is granted within 2 cycles.
- No wrap-around or counter state beyond the 1-bit pointer.

Test Plan:
- Reset, then port 0: ADD op1=5 op2=3, rsp0_ready=1 -> req0_ready=1 in cycle 0; cycle 1 rsp0_valid=1, data=8, err=0; last_grant=0.
- Both ports valid every cycle, all rsp_ready=1:
  - Port 0: SUB 10-4.
  - Port 1: SLT op1=0xFFFFFFFF op2=1.
  - Expected grants alternate 0,1,0,1. Port 0 results are 6. Port 1 results are 1.
- Backpressure: port 1 SRA 0x80000000 by 4 with rsp1_ready=0 for 5 cycles.
  - rsp1_data=0xF8000000 and stays stable.
  - Further port-1 requests are not accepted while the buffer is full.
  - Port 0 continues to be granted every cycle.
  - Release ready with a new request pending -> drain and refill in the same cycle.
- Illegal ctrl 4'hF on port 0 -> rsp0_valid=1, err=1, data=0, no X on any output.
- Assert rst with both buffers full and both requests valid -> next cycle all rsp_valid=0 and last_grant=1. The first post-reset contended cycle grants port 0.
- LUI op2=0x12345000 on port 1 alone -> data=0x12345000 one cycle later. Port 0 idle throughout; req0_ready stays 0.
